instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encoder counterpart to the ID-stage opcode decoder.
- Accepts field-level instruction descriptions (class, rs, rt, rd, shamt, funct, imm, target) over a valid/ready stream.
- Packs each description into a 32-bit MIPS word and writes it sequentially into instruction memory from a base address.
- Used by testbenches and the boot loader to fill instruction memory before the pipeline is released.

Parameters:
ADDR_W, 8, instruction-memory word-address width; the address counter wraps modulo 2^ADDR_W.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin a load session; sampled in IDLE or DONE only
base_addr  input  ADDR_W  first word address; sampled with start
num_words  input  ADDR_W+1  number of legal words to write; sampled with start
in_valid  input  1  instruction descriptor valid
in_ready  output  1  encoder can accept a descriptor this cycle
in_op  input  3  class: 0=R, 1=LW, 2=SW, 3=BNE, 4=XORI, 5=J, 6/7 illegal
in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift fields
in_funct  input  6  R-type function field
in_imm  input  16  immediate field for LW/SW/BNE/XORI
in_target  input  26  jump target field
mem_stall  input  1  instruction memory cannot take a write this cycle
imem_we  output  1  write strobe
imem_addr  output  ADDR_W  write word address
imem_wdata  output  32  encoded instruction
busy  output  1  state is LOAD or DRAIN
done  output  1  state is DONE
err_illegal  output  1  sticky flag: an illegal class was accepted this session
words_written  output  ADDR_W+1  count of completed writes this session

Behaviour:
- Reset values (asynchronous): state=IDLE; in_ready=0; imem_we=0; imem_addr=0; imem_wdata=0; busy=0; done=0; err_illegal=0; words_written=0; internal accept count=0.
- Reset asserted mid-session aborts the session immediately. Any pending write is dropped.
- FSM transitions:
  - IDLE --start--> LOAD. Latch base_addr and num_words; clear words_written and err_illegal.
  - If start is sampled with num_words=0, go directly to DONE on the next cycle. No write occurs.
  - LOAD -> DRAIN when accepted legal descriptors reach num_words.
  - DRAIN -> DONE when the output register is empty.
  - DONE holds done=1 until start, which begins a new session exactly as from IDLE.
  - start is ignored in LOAD and DRAIN.
- Input handshake:
  - A transfer occurs when in_valid && in_ready.
  - in_ready = (state==LOAD) && (legal accepted < num_words) && !(out_valid && mem_stall).
- Encoding (combinational from the accepted fields, registered into the output stage):
  - R: {6'b000000, rs, rt, rd, shamt, funct}
  - LW: {6'b100011, rs, rt, imm}
  - SW: {6'b101011, rs, rt, imm}
  - BNE: {6'b000101, rs, rt, imm}
  - XORI: {6'b001110, rs, rt, imm}
  - J: {6'b000010, target}
  - Fields not used by a class are ignored.
- Illegal class (6/7): handshake completes, nothing is written, err_illegal is set, and the accept count does not increment.
- Output stage and latency:
  - One-entry output register. A legal accept at cycle N gives imem_we=1 at cycle N+1.
  - imem_addr = base + words_written, mod 2^ADDR_W. Wrap from 2^ADDR_W-1 to 0 is legal and silent.
  - A write completes on a cycle where imem_we=1 and mem_stall=0. On completion, words_written increments.
  - If a new accept arrives in the same cycle as a completion, the register reloads and imem_we stays 1 (back-to-back, one word per cycle).
  - While mem_stall=1, imem_we, imem_addr and imem_wdata hold stable. No accept occurs.
- busy = (state==LOAD || state==DRAIN).

Test Plan:
1. Single R-type word:
   - Stimulus: reset, start with base=0x10, num=1; in_op=0, rs=9, rt=10, rd=8, shamt=0, funct=0x20.
   - Required: one cycle later imem_we=1, addr=0x10, wdata=0x012A4020; then done=1 and words_written=1.
2. Back-to-back mixed classes, base=0, num=5, in_valid held high:
   - LW rs=16 rt=9 imm=4 → 0x8E090004
   - SW rs=29 rt=31 imm=8 → 0xAFBF0008
   - BNE rs=1 rt=2 imm=0xFFFE → 0x1422FFFE
   - XORI rs=1 rt=2 imm=0xFFFF → 0x3822FFFF
   - J target=0x10 → 0x08000010
   - Required: five consecutive imem_we cycles at addresses 0..4.
3. Stall:
   - Stimulus: mem_stall=1 for 3 cycles while the second word is pending.
   - Required: addr/wdata stable and in_ready=0 during the stall; the write completes on the first cycle with mem_stall=0; no word lost or duplicated.
4. Wrap and illegal class:
   - Stimulus: base=0xFE, num=3, an illegal descriptor (in_op=6) inserted between legal ones.
   - Required: writes land at 0xFE, 0xFF, 0x00; err_illegal=1; words_written=3.
5. Boundary cases:
   - num_words=0: done=1 two cycles after start, imem_we never asserts.
   - start during LOAD: ignored.
   - reset asserted mid-session: all outputs return to their reset values immediately, independent of clk.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Packs field-level MIPS instruction descriptors into 32-bit words and streams them into instruction memory.
// One cycle from accept to imem_we; mem_stall freezes the output register and drops in_ready.
module instr_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              mem_stall,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   num_q;
    logic [ADDR_W:0]   acc_cnt;
    logic [ADDR_W:0]   acc_nx;
    logic              out_vld;
    logic [31:0]       out_dat;
    logic [31:0]       enc_dat;
    logic              op_legal;
    logic              accept;
    logic              accept_legal;
    logic              accept_illegal;
    logic              complete;
    logic              session_start;

    assign op_legal       = (in_op <= 3'd5);
    assign complete       = out_vld && !mem_stall;
    assign in_ready       = (state == LOAD) && (acc_cnt < num_q) && !(out_vld && mem_stall);
    assign accept         = in_valid && in_ready;
    assign accept_legal   = accept && op_legal;
    assign accept_illegal = accept && !op_legal;
    assign acc_nx         = acc_cnt + {{ADDR_W{1'b0}}, accept_legal};
    assign session_start  = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        enc_dat = 32'h0;
        case (in_op)
            3'd0:    enc_dat = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            3'd1:    enc_dat = {6'b100011, in_rs, in_rt, in_imm};
            3'd2:    enc_dat = {6'b101011, in_rs, in_rt, in_imm};
            3'd3:    enc_dat = {6'b000101, in_rs, in_rt, in_imm};
            3'd4:    enc_dat = {6'b001110, in_rs, in_rt, in_imm};
            3'd5:    enc_dat = {6'b000010, in_target};
            default: enc_dat = 32'h0;
        endcase
    end

    // An empty session skips LOAD/DRAIN entirely so no write can ever be issued.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = (num_words == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (acc_nx == num_q) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_vld) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            base_q        <= '0;
            num_q         <= '0;
            acc_cnt       <= '0;
            words_written <= '0;
            err_illegal   <= 1'b0;
            out_vld       <= 1'b0;
            out_dat       <= 32'h0;
        end else begin
            state <= state_nx;
            if (session_start) begin
                base_q        <= base_addr;
                num_q         <= num_words;
                acc_cnt       <= '0;
                words_written <= '0;
                err_illegal   <= 1'b0;
            end else begin
                acc_cnt <= acc_nx;
                if (accept_illegal) begin
                    err_illegal <= 1'b1;
                end
                if (complete) begin
                    words_written <= words_written + {{ADDR_W{1'b0}}, 1'b1};
                end
            end
            // A reload in the completion cycle keeps imem_we high for back-to-back writes.
            if (accept_legal) begin
                out_vld <= 1'b1;
                out_dat <= enc_dat;
            end else if (complete) begin
                out_vld <= 1'b0;
            end
        end
    end

    assign imem_we    = out_vld;
    assign imem_wdata = out_dat;
    assign imem_addr  = base_q + words_written[ADDR_W-1:0];
    assign busy       = (state == LOAD) || (state == DRAIN);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed stimulus against a queue-based model of the expected memory write stream.
module tb_instr_encoder_loader;

    typedef struct packed {
        logic [2:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tg;
    } desc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  num_words;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        mem_stall;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy, done, err_illegal;
    logic [8:0]  words_written;

    instr_encoder_loader #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_words(num_words),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
        .in_target(in_target), .mem_stall(mem_stall), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .err_illegal(err_illegal),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err = 0;
    logic [39:0] exp_q[$];
    logic [7:0]  addr_log[$];
    logic [7:0]  m_base;
    int          m_num, m_acc, m_written;
    bit          m_err;
    bit          sdone;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_model(input desc_t d);
        case (d.op)
            3'd0:    return {6'b000000, d.rs, d.rt, d.rd, d.sh, d.fn};
            3'd1:    return {6'b100011, d.rs, d.rt, d.imm};
            3'd2:    return {6'b101011, d.rs, d.rt, d.imm};
            3'd3:    return {6'b000101, d.rs, d.rt, d.imm};
            3'd4:    return {6'b001110, d.rs, d.rt, d.imm};
            3'd5:    return {6'b000010, d.tg};
            default: return 32'h0;
        endcase
    endfunction

    function automatic desc_t mk(input int op, input int rs, input int rt, input int rd,
                                 input int sh, input int fn, input int imm, input int tg);
        desc_t d;
        d.op = 3'(op); d.rs = 5'(rs); d.rt = 5'(rt); d.rd = 5'(rd); d.sh = 5'(sh);
        d.fn = 6'(fn); d.imm = 16'(imm); d.tg = 26'(tg);
        return d;
    endfunction

    function automatic desc_t rand_desc(input bit allow_illegal);
        return mk(allow_illegal ? $urandom_range(0, 7) : $urandom_range(0, 5), $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom, $urandom);
    endfunction

    // Every completed write must be the next model entry; stalled outputs must not move.
    initial begin
        bit          hold_prev = 0;
        logic [7:0]  prev_addr;
        logic [31:0] prev_data;
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_prev = 0;
            end else begin
                if (hold_prev) begin
                    chk("stall_hold_we", imem_we, 1'b1);
                    chk("stall_hold_addr", imem_addr, prev_addr);
                    chk("stall_hold_data", imem_wdata, prev_data);
                end
                chk("words_written", words_written, m_written);
                if (imem_we && mem_stall) chk("stall_ready", in_ready, 1'b0);
                if (imem_we && !mem_stall) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", imem_we, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_addr", imem_addr, e[39:32]);
                        chk("write_data", imem_wdata, e[31:0]);
                        m_written++;
                        addr_log.push_back(imem_addr);
                    end
                end
                hold_prev = imem_we && mem_stall;
                prev_addr = imem_addr;
                prev_data = imem_wdata;
            end
        end
    end

    task automatic start_session(input logic [7:0] b, input int n);
        start = 1; base_addr = b; num_words = 9'(n);
        @(posedge clk); #1;
        start = 0;
        m_base = b; m_num = n; m_acc = 0; m_written = 0; m_err = 0;
        addr_log.delete();
    endtask

    task automatic send(input desc_t d);
        bit ok = 0;
        in_valid = 1; in_op = d.op; in_rs = d.rs; in_rt = d.rt; in_rd = d.rd; in_shamt = d.sh;
        in_funct = d.fn; in_imm = d.imm; in_target = d.tg;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 0;
        chk("send_handshake", ok, 1'b1);
        if (ok) begin
            if (d.op <= 3'd5) begin
                exp_q.push_back({m_base + 8'(m_acc), enc_model(d)});
                m_acc++;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic wait_done_and_check(input string nm);
        bit seen = 0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            seen = done;
        end
        @(posedge clk); #1;
        chk({nm, "_done"}, done, 1'b1);
        chk({nm, "_busy"}, busy, 1'b0);
        chk({nm, "_words"}, words_written, m_num);
        chk({nm, "_err"}, err_illegal, m_err);
    endtask

    desc_t       d;
    desc_t       t2[5];
    logic [31:0] t2e[5];

    initial begin
        reset = 1; start = 0; base_addr = 0; num_words = 0; in_valid = 0; in_op = 0;
        in_rs = 0; in_rt = 0; in_rd = 0; in_shamt = 0; in_funct = 0; in_imm = 0; in_target = 0;
        mem_stall = 0; m_base = 0; m_num = 0; m_acc = 0; m_written = 0; m_err = 0; sdone = 0;
        #12;
        chk("rst_in_ready", in_ready, 0); chk("rst_we", imem_we, 0); chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_err", err_illegal, 0); chk("rst_words", words_written, 0);
        @(posedge clk); #1;
        reset = 0;

        // single R-type word
        d = mk(0, 9, 10, 8, 0, 'h20, 0, 0);
        chk("model_r", enc_model(d), 32'h012A4020);
        start_session(8'h10, 1);
        send(d);
        chk("t1_we", imem_we, 1'b1);
        chk("t1_addr", imem_addr, 8'h10);
        chk("t1_wdata", imem_wdata, 32'h012A4020);
        wait_done_and_check("t1");

        // back-to-back mixed classes
        t2[0] = mk(1, 16, 9, 0, 0, 0, 4, 0);       t2e[0] = 32'h8E090004;
        t2[1] = mk(2, 29, 31, 0, 0, 0, 8, 0);      t2e[1] = 32'hAFBF0008;
        t2[2] = mk(3, 1, 2, 0, 0, 0, 'hFFFE, 0);   t2e[2] = 32'h1422FFFE;
        t2[3] = mk(4, 1, 2, 0, 0, 0, 'hFFFF, 0);   t2e[3] = 32'h3822FFFF;
        t2[4] = mk(5, 0, 0, 0, 0, 0, 0, 'h10);     t2e[4] = 32'h08000010;
        for (int i = 0; i < 5; i++) chk("model_t2", enc_model(t2[i]), t2e[i]);
        start_session(8'h00, 5);
        fork
            begin
                for (int i = 0; i < 5; i++) send(t2[i]);
            end
            begin
                int w = 0;
                @(negedge clk);
                while (!imem_we && w < 50) begin @(negedge clk); w++; end
                for (int i = 0; i < 5; i++) begin
                    chk("b2b_we", imem_we, 1'b1);
                    chk("b2b_addr", imem_addr, i);
                    if (i < 4) @(negedge clk);
                end
            end
        join
        wait_done_and_check("t2");

        // stall while the second word is pending
        start_session(8'h20, 3);
        fork
            begin
                for (int i = 0; i < 3; i++) send(rand_desc(0));
            end
            begin
                int w = 0;
                while (!(imem_we && imem_addr == 8'h21) && w < 100) begin @(posedge clk); #1; w++; end
                mem_stall = 1;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall3_ready", in_ready, 1'b0);
                    chk("stall3_addr", imem_addr, 8'h21);
                    @(posedge clk); #1;
                end
                mem_stall = 0;
                @(negedge clk);
                chk("stall3_release_we", imem_we, 1'b1);
                chk("stall3_release_addr", imem_addr, 8'h21);
            end
        join
        wait_done_and_check("t3");

        // address wrap with an illegal descriptor in the middle
        start_session(8'hFE, 3);
        send(mk(1, 3, 4, 0, 0, 0, 'h1234, 0));
        send(mk(6, 1, 1, 1, 1, 1, 1, 1));
        send(mk(2, 5, 6, 0, 0, 0, 'h0040, 0));
        send(mk(5, 0, 0, 0, 0, 0, 0, 'h3FFFFFF));
        wait_done_and_check("t4");
        chk("t4_err_lit", err_illegal, 1'b1);
        chk("t4_nlog", addr_log.size(), 3);
        if (addr_log.size() == 3) begin
            chk("t4_a0", addr_log[0], 8'hFE);
            chk("t4_a1", addr_log[1], 8'hFF);
            chk("t4_a2", addr_log[2], 8'h00);
        end

        // empty session
        start_session(8'h40, 0);
        @(posedge clk); #1;
        chk("t5_empty_done", done, 1'b1);
        chk("t5_empty_busy", busy, 1'b0);
        chk("t5_empty_words", words_written, 0);

        // start during LOAD is ignored
        start_session(8'h30, 2);
        send(rand_desc(0));
        start = 1; base_addr = 8'h80; num_words = 9'd1;
        @(posedge clk); #1;
        start = 0;
        chk("t5_ign_busy", busy, 1'b1);
        send(rand_desc(0));
        wait_done_and_check("t5_ign");

        // reset mid-session drops the pending write
        start_session(8'h50, 4);
        send(mk(7, 0, 0, 0, 0, 0, 0, 0));
        send(rand_desc(0));
        chk("t5_pre_err", err_illegal, 1'b1);
        chk("t5_pre_we", imem_we, 1'b1);
        #2;
        reset = 1;
        #1;
        chk("t5_rst_in_ready", in_ready, 0); chk("t5_rst_we", imem_we, 0);
        chk("t5_rst_addr", imem_addr, 0); chk("t5_rst_wdata", imem_wdata, 0);
        chk("t5_rst_busy", busy, 0); chk("t5_rst_done", done, 0);
        chk("t5_rst_err", err_illegal, 0); chk("t5_rst_words", words_written, 0);
        exp_q.delete(); m_written = 0; m_acc = 0;
        @(posedge clk); #1;
        reset = 0;

        // randomized sessions with random gaps and stalls
        for (int s = 0; s < 8; s++) begin
            start_session(8'($urandom_range(0, 255)), $urandom_range(1, 12));
            sdone = 0;
            fork
                begin
                    for (int it = 0; it < 64 && m_acc < m_num; it++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        send(rand_desc(1));
                    end
                    sdone = 1;
                end
                begin
                    while (!sdone) begin
                        mem_stall = ($urandom_range(0, 2) == 0);
                        @(posedge clk); #1;
                    end
                    mem_stall = 0;
                end
            join
            wait_done_and_check("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
